decode_pipe: RTL and testbench

//   Parametrised decode stage with an integrated D->E pipeline register.
//   - Decodes the fetched instruction and reads the register file, which has write-first bypass.
//   - Detects load-use hazards and inserts bubbles.
//   - Honours execute back-pressure (ready_e) and branch/jump flush (flush_d).
//   - Sits between fetch and execute; every *_e output is registered.

---
 rtl/riscv_pkg.sv | 80 ++++++++
 rtl/control_unit.sv | 77 +++++++
 rtl/imm_ext.sv | 31 +++
 rtl/reg_file_bypass.sv | 60 ++++++
 rtl/decode_pipe.sv | 158 +++++++++++++++
 tb/tb_decode_pipe.sv | 260 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared decode constants: opcodes, result-source codes, ALU
//               operation encodings, immediate formats and the control word.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Result source selection in writeback
    localparam logic [1:0] RES_SRC_ALU  = 2'b00;
    localparam logic [1:0] RES_SRC_LOAD = 2'b01;
    localparam logic [1:0] RES_SRC_PC4  = 2'b10;

    // ALU operation encodings
    localparam logic [5:0] ALU_ADD    = 6'd0;
    localparam logic [5:0] ALU_SUB    = 6'd1;
    localparam logic [5:0] ALU_SLL    = 6'd2;
    localparam logic [5:0] ALU_SLT    = 6'd3;
    localparam logic [5:0] ALU_SLTU   = 6'd4;
    localparam logic [5:0] ALU_XOR    = 6'd5;
    localparam logic [5:0] ALU_SRL    = 6'd6;
    localparam logic [5:0] ALU_SRA    = 6'd7;
    localparam logic [5:0] ALU_OR     = 6'd8;
    localparam logic [5:0] ALU_AND    = 6'd9;
    localparam logic [5:0] ALU_PASS_B = 6'd10;

    // funct7 value that selects the packed (zero-extended) immediate form
    localparam logic [6:0] PACKED_FUNCT7 = 7'b1110111;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_src_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       adder_src;
        logic [1:0] res_src;
        logic [5:0] alu_control;
        imm_src_t   imm_src;
    } ctrl_t;

    // ALU operation from funct3/funct7[5]; SUB exists only for register ops
    function automatic logic [5:0] alu_decode(input logic [2:0] funct3,
                                              input logic       funct7b5,
                                              input logic       is_reg);
        case (funct3)
            3'b000:  return (is_reg && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Main decoder producing the control word from opcode/funct.
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit
    import riscv_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    output ctrl_t      o_ctrl
);

    // Opcode decode; unknown opcodes produce an all-inactive control word
    always_comb begin
        o_ctrl             = '0;
        o_ctrl.imm_src     = IMM_I;
        o_ctrl.alu_control = ALU_ADD;
        case (i_opcode)
            OP_LOAD: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src_b = 1'b1;
                o_ctrl.res_src   = RES_SRC_LOAD;
            end
            OP_STORE: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.alu_src_b = 1'b1;
                o_ctrl.imm_src   = IMM_S;
            end
            OP_REG: begin
                o_ctrl.reg_write   = 1'b1;
                o_ctrl.alu_control = alu_decode(i_funct3, i_funct7b5, 1'b1);
            end
            OP_IMM: begin
                o_ctrl.reg_write   = 1'b1;
                o_ctrl.alu_src_b   = 1'b1;
                o_ctrl.alu_control = alu_decode(i_funct3, i_funct7b5, 1'b0);
            end
            OP_BRANCH: begin
                o_ctrl.branch      = 1'b1;
                o_ctrl.imm_src     = IMM_B;
                o_ctrl.alu_control = ALU_SUB;
            end
            OP_JAL: begin
                o_ctrl.jump      = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.res_src   = RES_SRC_PC4;
                o_ctrl.imm_src   = IMM_J;
            end
            OP_JALR: begin
                o_ctrl.jump      = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.res_src   = RES_SRC_PC4;
                o_ctrl.adder_src = 1'b1;
            end
            OP_LUI: begin
                o_ctrl.reg_write   = 1'b1;
                o_ctrl.alu_src_b   = 1'b1;
                o_ctrl.imm_src     = IMM_U;
                o_ctrl.alu_control = ALU_PASS_B;
            end
            OP_AUIPC: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = 1'b1;
                o_ctrl.imm_src   = IMM_U;
            end
            default: begin
                o_ctrl.imm_src = IMM_I;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imm_ext.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext
// Description : Standard RV32 immediate extraction with sign extension.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_ext
    import riscv_pkg::*;
(
    input  logic [31:7] i_instr,
    input  imm_src_t    i_imm_src,
    output logic [31:0] o_imm
);

    // Reassemble the immediate bits for the selected instruction format
    always_comb begin
        o_imm = '0;
        case (i_imm_src)
            IMM_I:   o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S:   o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B:   o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                              i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_J:   o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                              i_instr[20], i_instr[30:21], 1'b0};
            IMM_U:   o_imm = {i_instr[31:12], 12'b0};
            default: o_imm = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/reg_file_bypass.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_bypass
// Description : Two-read/one-write register file, x0 hardwired to zero,
//               write-first bypass on same-cycle read of the write address.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_bypass #(
    parameter  int NUM_REGS   = 32,
    parameter  int DATA_WIDTH = 32,
    localparam int REG_AW     = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [REG_AW-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [REG_AW-1:0]     i_raddr1,
    input  logic [REG_AW-1:0]     i_raddr2,
    output logic [DATA_WIDTH-1:0] o_rdata1,
    output logic [DATA_WIDTH-1:0] o_rdata2
);

    localparam logic [REG_AW:0] c_num_regs = (REG_AW + 1)'(NUM_REGS);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic                  w_write;

    // Writes to x0 or to an index beyond the array are dropped
    assign w_write = i_we && (i_waddr != '0) && ({1'b0, i_waddr} < c_num_regs);

    // Register array update; reset clears every entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_write) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Read port 1: x0/out-of-range read zero, pending write wins over the array
    always_comb begin
        o_rdata1 = '0;
        if ((i_raddr1 != '0) && ({1'b0, i_raddr1} < c_num_regs)) begin
            o_rdata1 = (w_write && (i_waddr == i_raddr1)) ? i_wdata : r_regs[i_raddr1];
        end
    end

    // Read port 2: same behaviour as port 1
    always_comb begin
        o_rdata2 = '0;
        if ((i_raddr2 != '0) && ({1'b0, i_raddr2} < c_num_regs)) begin
            o_rdata2 = (w_write && (i_waddr == i_raddr2)) ? i_wdata : r_regs[i_raddr2];
        end
    end

endmodule
`default_nettype wire

// File: rtl/decode_pipe.sv
`default_nettype none
// ============================================================================
// Module      : decode_pipe
// Description : Decode stage with integrated D->E pipeline register,
//               load-use bubble insertion, back-pressure and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_pipe #(
    parameter  int ADDRESS_WIDTH = 32,
    parameter  int DATA_WIDTH    = 32,
    parameter  int NUM_REGS      = 32,
    parameter  bit IMM_PACKED_EN = 1'b1,
    localparam int REG_AW        = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_f,
    output logic                     ready_d,
    input  logic [31:0]              instr_f,
    input  logic [ADDRESS_WIDTH-1:0] pc_f,
    input  logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
    input  logic                     reg_write_w,
    input  logic [REG_AW-1:0]        rd_w,
    input  logic [DATA_WIDTH-1:0]    result_w,
    input  logic                     ready_e,
    input  logic                     flush_d,
    output logic                     valid_e,
    output logic                     reg_write_e,
    output logic                     mem_write_e,
    output logic                     jump_e,
    output logic                     branch_e,
    output logic                     alu_src_a_e,
    output logic                     alu_src_b_e,
    output logic                     adder_src_e,
    output logic [1:0]               res_src_e,
    output logic [5:0]               alu_control_e,
    output logic [2:0]               funct3_e,
    output logic [DATA_WIDTH-1:0]    rd1_e,
    output logic [DATA_WIDTH-1:0]    rd2_e,
    output logic [DATA_WIDTH-1:0]    imm_val_e,
    output logic [ADDRESS_WIDTH-1:0] pc_e,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
    output logic [REG_AW-1:0]        rs1_e,
    output logic [REG_AW-1:0]        rs2_e,
    output logic [REG_AW-1:0]        rd_e
);

    import riscv_pkg::*;

    ctrl_t                  w_ctrl;
    logic [2:0]             w_funct3;
    logic [6:0]             w_funct7;
    logic [REG_AW-1:0]      w_rs1;
    logic [REG_AW-1:0]      w_rs2;
    logic [REG_AW-1:0]      w_rd;
    logic [31:0]            w_imm_std;
    logic [DATA_WIDTH-1:0]  w_imm_packed;
    logic [DATA_WIDTH-1:0]  w_imm;
    logic [DATA_WIDTH-1:0]  w_rd1;
    logic [DATA_WIDTH-1:0]  w_rd2;
    logic                   w_load_use;
    logic                   w_bubble;

    assign w_funct3 = instr_f[14:12];
    assign w_funct7 = instr_f[31:25];
    assign w_rs1    = REG_AW'(instr_f[19:15]);
    assign w_rs2    = REG_AW'(instr_f[24:20]);
    assign w_rd     = REG_AW'(instr_f[11:7]);

    control_unit u_control_unit (
        .i_opcode   (instr_f[6:0]),
        .i_funct3   (w_funct3),
        .i_funct7b5 (w_funct7[5]),
        .o_ctrl     (w_ctrl)
    );

    imm_ext u_imm_ext (
        .i_instr   (instr_f[31:7]),
        .i_imm_src (w_ctrl.imm_src),
        .o_imm     (w_imm_std)
    );

    reg_file_bypass #(
        .NUM_REGS   (NUM_REGS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .i_we     (reg_write_w),
        .i_waddr  (rd_w),
        .i_wdata  (result_w),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .o_rdata1 (w_rd1),
        .o_rdata2 (w_rd2)
    );

    // Packed form takes a zero-extended 4- or 5-bit field from the rs2 slot
    assign w_imm_packed = w_funct3[2] ? DATA_WIDTH'(instr_f[23:20]) : DATA_WIDTH'(instr_f[24:20]);
    assign w_imm = (IMM_PACKED_EN && (w_funct7 == PACKED_FUNCT7))
                 ? w_imm_packed
                 : DATA_WIDTH'($signed(w_imm_std));

    // A load in E whose destination is a source of the fetch word must wait one cycle
    assign w_load_use = valid_e && (res_src_e == RES_SRC_LOAD) && (rd_e != '0) && valid_f
                     && ((rd_e == w_rs1) || (rd_e == w_rs2));

    // A flush kills the fetch word, so it is consumed even during a load-use hazard
    assign ready_d  = !rst && ready_e && (!w_load_use || flush_d);
    assign w_bubble = flush_d || !valid_f || w_load_use;

    // E-register: reset/bubble clear it, a stalled execute holds it, otherwise load
    always_ff @(posedge clk) begin
        if (rst || (ready_e && w_bubble)) begin
            valid_e       <= 1'b0;
            reg_write_e   <= 1'b0;
            mem_write_e   <= 1'b0;
            jump_e        <= 1'b0;
            branch_e      <= 1'b0;
            alu_src_a_e   <= 1'b0;
            alu_src_b_e   <= 1'b0;
            adder_src_e   <= 1'b0;
            res_src_e     <= '0;
            alu_control_e <= '0;
            funct3_e      <= '0;
            rd1_e         <= '0;
            rd2_e         <= '0;
            imm_val_e     <= '0;
            pc_e          <= '0;
            pc_plus4_e    <= '0;
            rs1_e         <= '0;
            rs2_e         <= '0;
            rd_e          <= '0;
        end else if (ready_e) begin
            valid_e       <= 1'b1;
            reg_write_e   <= w_ctrl.reg_write;
            mem_write_e   <= w_ctrl.mem_write;
            jump_e        <= w_ctrl.jump;
            branch_e      <= w_ctrl.branch;
            alu_src_a_e   <= w_ctrl.alu_src_a;
            alu_src_b_e   <= w_ctrl.alu_src_b;
            adder_src_e   <= w_ctrl.adder_src;
            res_src_e     <= w_ctrl.res_src;
            alu_control_e <= w_ctrl.alu_control;
            funct3_e      <= w_funct3;
            rd1_e         <= w_rd1;
            rd2_e         <= w_rd2;
            imm_val_e     <= w_imm;
            pc_e          <= pc_f;
            pc_plus4_e    <= pc_plus4_f;
            rs1_e         <= w_rs1;
            rs2_e         <= w_rs2;
            rd_e          <= w_rd;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_pipe
// Description : Scoreboard bench for decode_pipe: stimulus pushes expected
//               E-register contents, a monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_pipe;

    logic        clk;
    logic        rst;
    logic        valid_f;
    logic        ready_d;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
    logic        reg_write_w;
    logic [4:0]  rd_w;
    logic [31:0] result_w;
    logic        ready_e;
    logic        flush_d;
    logic        valid_e;
    logic        reg_write_e;
    logic        mem_write_e;
    logic        jump_e;
    logic        branch_e;
    logic        alu_src_a_e;
    logic        alu_src_b_e;
    logic        adder_src_e;
    logic [1:0]  res_src_e;
    logic [5:0]  alu_control_e;
    logic [2:0]  funct3_e;
    logic [31:0] rd1_e;
    logic [31:0] rd2_e;
    logic [31:0] imm_val_e;
    logic [31:0] pc_e;
    logic [31:0] pc_plus4_e;
    logic [4:0]  rs1_e;
    logic [4:0]  rs2_e;
    logic [4:0]  rd_e;

    decode_pipe u_dut (
        .clk           (clk),
        .rst           (rst),
        .valid_f       (valid_f),
        .ready_d       (ready_d),
        .instr_f       (instr_f),
        .pc_f          (pc_f),
        .pc_plus4_f    (pc_plus4_f),
        .reg_write_w   (reg_write_w),
        .rd_w          (rd_w),
        .result_w      (result_w),
        .ready_e       (ready_e),
        .flush_d       (flush_d),
        .valid_e       (valid_e),
        .reg_write_e   (reg_write_e),
        .mem_write_e   (mem_write_e),
        .jump_e        (jump_e),
        .branch_e      (branch_e),
        .alu_src_a_e   (alu_src_a_e),
        .alu_src_b_e   (alu_src_b_e),
        .adder_src_e   (adder_src_e),
        .res_src_e     (res_src_e),
        .alu_control_e (alu_control_e),
        .funct3_e      (funct3_e),
        .rd1_e         (rd1_e),
        .rd2_e         (rd2_e),
        .imm_val_e     (imm_val_e),
        .pc_e          (pc_e),
        .pc_plus4_e    (pc_plus4_e),
        .rs1_e         (rs1_e),
        .rs2_e         (rs2_e),
        .rd_e          (rd_e)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        rw;
        logic        mw;
        logic        asb;
        logic [1:0]  res;
        logic [2:0]  f3;
        logic [5:0]  alu;
    } exp_t;

    exp_t q_exp[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        valid_f    = 1'b1;
        instr_f    = instr;
        pc_f       = pc;
        pc_plus4_f = pc + 32'd4;
    endtask

    task automatic push(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic [31:0] pc,
                        input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic rw, input logic mw, input logic asb,
                        input logic [1:0] res, input logic [2:0] f3, input logic [5:0] alu);
        exp_t e;
        e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.pc = pc;
        e.rd1 = rd1; e.rd2 = rd2; e.rw = rw; e.mw = mw; e.asb = asb;
        e.res = res; e.f3 = f3; e.alu = alu;
        q_exp.push_back(e);
    endtask

    // Monitor: a new E entry exists when execute accepted at the edge and valid_e is set
    initial begin
        logic accepted;
        exp_t e;
        forever begin
            @(posedge clk);
            accepted = ready_e && !rst;
            @(negedge clk);
            if (accepted && valid_e) begin
                if (q_exp.size() == 0) begin
                    chk("unexpected_entry_pc", pc_e, 32'hFFFF_FFFF);
                end else begin
                    e = q_exp.pop_front();
                    chk("rd_e",          32'(rd_e), 32'(e.rd));
                    chk("rs1_e",         32'(rs1_e), 32'(e.rs1));
                    chk("rs2_e",         32'(rs2_e), 32'(e.rs2));
                    chk("imm_val_e",     imm_val_e, e.imm);
                    chk("pc_e",          pc_e, e.pc);
                    chk("pc_plus4_e",    pc_plus4_e, e.pc + 32'd4);
                    chk("rd1_e",         rd1_e, e.rd1);
                    chk("rd2_e",         rd2_e, e.rd2);
                    chk("reg_write_e",   32'(reg_write_e), 32'(e.rw));
                    chk("mem_write_e",   32'(mem_write_e), 32'(e.mw));
                    chk("alu_src_b_e",   32'(alu_src_b_e), 32'(e.asb));
                    chk("res_src_e",     32'(res_src_e), 32'(e.res));
                    chk("funct3_e",      32'(funct3_e), 32'(e.f3));
                    chk("alu_control_e", 32'(alu_control_e), 32'(e.alu));
                    chk("jmp_br_srca_adder", 32'({jump_e, branch_e, alu_src_a_e, adder_src_e}), 32'd0);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        rst = 1'b1; valid_f = 1'b0; instr_f = '0; pc_f = '0; pc_plus4_f = '0;
        reg_write_w = 1'b0; rd_w = '0; result_w = '0; ready_e = 1'b1; flush_d = 1'b0;

        // Reset
        step(); step();
        chk("rst_ready_d", 32'(ready_d), 32'd0);
        chk("rst_valid_e", 32'(valid_e), 32'd0);
        chk("rst_pc_e", pc_e, 32'd0);
        chk("rst_imm_val_e", imm_val_e, 32'd0);
        chk("rst_ctrl", 32'({reg_write_e, mem_write_e, res_src_e, alu_control_e, rd_e}), 32'd0);
        rst = 1'b0;
        step();
        chk("idle_valid_e", 32'(valid_e), 32'd0);
        chk("idle_ready_d", 32'(ready_d), 32'd1);

        // addi x5, x0, -3
        present(32'hFFD00293, 32'h100);
        push(5'd5, 5'd0, 5'd29, 32'hFFFF_FFFD, 32'h100, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 2'b00, 3'd0, 6'd0);
        step();

        // add x1, x7, x0 with same-cycle writeback of x7
        present(32'h000380B3, 32'h104);
        reg_write_w = 1'b1; rd_w = 5'd7; result_w = 32'hA5A5_A5A5;
        push(5'd1, 5'd7, 5'd0, 32'd0, 32'h104, 32'hA5A5_A5A5, 32'd0, 1'b1, 1'b0, 1'b0, 2'b00, 3'd0, 6'd0);
        step();

        // lw x3, 0(x2), while writing back x1 = 0x12345678
        present(32'h00012183, 32'h108);
        rd_w = 5'd1; result_w = 32'h1234_5678;
        push(5'd3, 5'd2, 5'd0, 32'd0, 32'h108, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 2'b01, 3'd2, 6'd0);
        step();
        reg_write_w = 1'b0; rd_w = '0; result_w = '0;

        // add x4, x3, x1 depends on the load: one bubble, then issue
        present(32'h00118233, 32'h10C);
        #1;
        chk("load_use_ready_d", 32'(ready_d), 32'd0);
        step();
        chk("load_use_bubble_valid_e", 32'(valid_e), 32'd0);
        chk("after_bubble_ready_d", 32'(ready_d), 32'd1);
        push(5'd4, 5'd3, 5'd1, 32'd1, 32'h10C, 32'd0, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 2'b00, 3'd0, 6'd0);
        step();

        // sw x5, 8(x2)
        present(32'h00512423, 32'h110);
        push(5'd8, 5'd2, 5'd5, 32'd8, 32'h110, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 2'b00, 3'd2, 6'd0);
        step();

        // Back-pressure: the store must stay in E for three cycles
        present(32'hEF614313, 32'h114);
        ready_e = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ready_d", 32'(ready_d), 32'd0);
            step();
            chk("stall_valid_e", 32'(valid_e), 32'd1);
            chk("stall_pc_e", pc_e, 32'h110);
            chk("stall_imm_val_e", imm_val_e, 32'd8);
        end

        // Release with flush: the word in decode is killed
        ready_e = 1'b1; flush_d = 1'b1;
        step();
        chk("flush_valid_e", 32'(valid_e), 32'd0);
        flush_d = 1'b0;

        // Packed immediate, funct3 = 100 -> instr[23:20]
        present(32'hEF614313, 32'h114);
        push(5'd6, 5'd2, 5'd22, 32'h6, 32'h114, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 2'b00, 3'd4, 6'd5);
        step();

        // Packed immediate, funct3 = 000 -> instr[24:20]
        present(32'hEF610313, 32'h118);
        push(5'd6, 5'd2, 5'd22, 32'h16, 32'h118, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 2'b00, 3'd0, 6'd0);
        step();

        valid_f = 1'b0;
        step();
        chk("drain_valid_e", 32'(valid_e), 32'd0);
        step();
        chk("queue_empty", 32'(q_exp.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
